// File: rtl/rs232_des_pkg.sv
// Shared RS-232 definitions: FSM state encodings, frame constants and the
// clogb2 helper used to size bit-period counters.
package rs232_des_pkg;

    // Frame format: 8 data bits, LSB first, no parity, 1 stop bit.
    localparam int FRAME_DATA_BITS = 8;
    localparam int FRAME_STOP_BITS = 1;

    // Receive/transmit FSM states, shared by serializer and deserializer.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rs232_state_e;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rs232_des_if.sv
// Downstream byte interface of the RS-232 deserializer.
//
// Handshake: rx_req (valid) rises with a new byte on rx_data and stays high,
// with rx_data stable, until the consumer returns a one-cycle rx_ack (ready);
// rx_req drops on the edge after the cycle in which rx_ack is sampled high.
// rx_ack while rx_req is low is ignored. rx_frame_err and rx_overrun are
// single-cycle status pulses. dbg_state mirrors the receive FSM state.
interface rs232_des_if;
    import rs232_des_pkg::*;

    logic [FRAME_DATA_BITS-1:0] rx_data;
    logic                       rx_req;
    logic                       rx_ack;
    logic                       rx_frame_err;
    logic                       rx_overrun;
    rs232_state_e               dbg_state;

    // Deserializer side.
    modport master (
        output rx_data,
        output rx_req,
        output rx_frame_err,
        output rx_overrun,
        output dbg_state,
        input  rx_ack
    );

    // Consumer side.
    modport slave (
        input  rx_data,
        input  rx_req,
        input  rx_frame_err,
        input  rx_overrun,
        input  dbg_state,
        output rx_ack
    );

endinterface

// File: rtl/rs232_des_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module rs232_des_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next values: each stage copies the one before it.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer flops, preset to the idle line level on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/rs232_des.sv
// RS-232 8N1 deserializer: samples rx at mid-bit, assembles bytes LSB first
// and offers them downstream through the req/ack interface.
module rs232_des
    import rs232_des_pkg::*;
#(
    parameter int P_CLK_FREQ_HZ = 100000000,
    parameter int P_BAUD_RATE   = 9600
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    rs232_des_if.master   bus
);

    localparam int BIT_CLKS  = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int NBITS_CNT = clogb2(BIT_CLKS);

    localparam logic [NBITS_CNT-1:0] CNT_BIT_LAST  = NBITS_CNT'(BIT_CLKS - 1);
    localparam logic [NBITS_CNT-1:0] CNT_HALF_LAST = NBITS_CNT'(HALF_CLKS - 1);
    localparam logic [NBITS_CNT-1:0] CNT_ONE       = NBITS_CNT'(1);
    localparam logic [2:0]           BIT_IDX_LAST  = 3'(FRAME_DATA_BITS - 1);

    logic rx_s;

    rs232_state_e                state_q,     state_d;
    logic [NBITS_CNT-1:0]        cnt_q,       cnt_d;
    logic [2:0]                  bit_cnt_q,   bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0]  shift_q,     shift_d;
    logic [FRAME_DATA_BITS-1:0]  rx_data_q,   rx_data_d;
    logic                        rx_req_q,    rx_req_d;
    logic                        frame_err_q, frame_err_d;
    logic                        overrun_q,   overrun_d;

    rs232_des_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state, datapath and handshake logic for the receive FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Ack is applied before any stop-bit acceptance in the same cycle, so
        // a byte completing alongside an ack is delivered, not dropped.
        rx_req_d = rx_req_q && !bus.rx_ack;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    // A line back at mark by mid-start-bit was only a glitch.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_SHIFT: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (!rx_req_d) begin
                            rx_data_d = shift_q;
                            rx_req_d  = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_BREAK: begin
                // Hold off until the line returns to mark so a long break
                // is not decoded as a run of 8'h00 bytes.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_req_q    <= rx_req_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_req       = rx_req_q;
    assign bus.rx_frame_err = frame_err_q;
    assign bus.rx_overrun   = overrun_q;
    assign bus.dbg_state    = state_q;

endmodule
